// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared types and constants for the APB register-file responder
// Provides the FSM state enum, bus widths, the value returned for out-of-range reads,
// and a onehot0 helper for the bridge select vector.
package apb_slv_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_ADDR_W = 32;
    localparam logic [APB_DATA_W-1:0] APB_OOR_RDATA = 32'h0;
    function automatic logic onehot0(input logic [2:0] v);
        return (v & (v - 3'd1)) == 3'd0;
    endfunction
endpackage

// File: rtl/apb_slv_regbank.sv
// apb_slv_regbank: DEPTH x 32 register storage, one write port, one read port
// Ports: clk_i clock; rst_i sync active-high clear of all registers; we_i/waddr_i/wdata_i
// write port; raddr_i/rdata_o combinational read port with write-first bypass.
module apb_slv_regbank
    import apb_slv_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [APB_DATA_W-1:0]    wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [APB_DATA_W-1:0]    rdata_o
);
    logic [APB_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A read landing on the register being written sees the new value
    assign rdata_o = (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB register-file responder behind one bridge slave select
// Ports: Hclk clock; Hreset sync active-high reset; Pselx/Penable/Pwrite/Paddr/Pwdata
// APB request from the bridge; Prdata read data; proto_err sticky protocol-violation flag;
// Pready transfer-complete, present only when APB_SLV_PREADY_EN is defined (which also
// adds the WAIT_CYCLES parameter and the access-phase wait counter).
module apb_slave_regfile
    import apb_slv_pkg::*;
#(
    parameter int unsigned           SEL_IDX   = 0,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned           DEPTH     = 16
`ifdef APB_SLV_PREADY_EN
    ,
    parameter int unsigned           WAIT_CYCLES = 0
`endif
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic [2:0]            Pselx,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [APB_ADDR_W-1:0] Paddr,
    input  logic [APB_DATA_W-1:0] Pwdata,
    output logic [APB_DATA_W-1:0] Prdata,
`ifdef APB_SLV_PREADY_EN
    output logic                  Pready,
`endif
    output logic                  proto_err
);
    localparam int unsigned AW = $clog2(DEPTH);

    apb_state_e            state_q, state_d, cur;
    logic [APB_ADDR_W-1:0] addr_q, off;
    logic [APB_DATA_W-1:0] prdata_q, rdata;
    logic [AW-1:0]         idx;
    logic                  write_q, err_q, sel, in_range, rdy, viol, hold_err, we;

    assign sel      = Pselx[SEL_IDX];
    assign off      = Paddr - BASE_ADDR;
    assign in_range = off < APB_ADDR_W'(DEPTH * 4);
    assign idx      = off[AW+1:2];

    // The setup cycle is recognised from the live bus, so SETUP is the phase of the
    // current cycle rather than a registered state; the register only holds IDLE/ACCESS.
    assign cur = (state_q == IDLE && sel && !Penable) ? SETUP : state_q;

`ifdef APB_SLV_PREADY_EN
    localparam int unsigned CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [CW-1:0]         cnt_q;
    logic [APB_DATA_W-1:0] wdata_q;
    assign rdy      = cur != ACCESS || cnt_q == '0;
    assign hold_err = Pwdata != wdata_q;
    assign Pready   = rdy;
`else
    assign rdy      = 1'b1;
    assign hold_err = 1'b0;
`endif

    assign viol = !onehot0(Pselx) || (cur == IDLE && Penable) ||
                  (cur == ACCESS && (!Penable || Paddr != addr_q || Pwrite != write_q || hold_err));
    // Paddr equals the latched address whenever no violation is flagged, so the live
    // decode doubles as the write index
    assign we      = cur == ACCESS && rdy && !viol && write_q && in_range;
    assign state_d = (cur == SETUP || (cur == ACCESS && !rdy && !viol)) ? ACCESS : IDLE;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            prdata_q <= '0;
            err_q    <= 1'b0;
`ifdef APB_SLV_PREADY_EN
            cnt_q    <= '0;
            wdata_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_q | viol;
            if (cur == SETUP) begin
                addr_q  <= Paddr;
                write_q <= Pwrite;
                if (!Pwrite) prdata_q <= in_range ? rdata : APB_OOR_RDATA;
            end
`ifdef APB_SLV_PREADY_EN
            if (cur == SETUP) begin
                cnt_q   <= CW'(WAIT_CYCLES);
                wdata_q <= Pwdata;
            end else if (cur == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
`endif
        end
    end

    apb_slv_regbank #(.DEPTH(DEPTH)) u_bank (
        .clk_i   (Hclk),
        .rst_i   (Hreset),
        .we_i    (we),
        .waddr_i (idx),
        .wdata_i (Pwdata),
        .raddr_i (idx),
        .rdata_o (rdata)
    );

    assign Prdata    = prdata_q;
    assign proto_err = err_q;
endmodule
